// File: rtl/simd_pkg.sv
// Shared opcode encoding and constants for the SIMD execute pipeline.
package simd_pkg;

    typedef enum logic [3:0] {
        OP_PASS  = 4'd0,
        OP_XOR   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_ADD   = 4'd4,
        OP_SUB   = 4'd5,
        OP_SHL   = 4'd6,
        OP_XTIME = 4'd7
    } op_e;

    // AES field reduction polynomial x^8 + x^4 + x^3 + x + 1, low byte only.
    localparam logic [7:0] AES_POLY = 8'h1B;

    // Codes 8-15 are reserved; the top bit alone identifies them.
    function automatic logic is_legal_op(input logic [3:0] sel);
        return !sel[3];
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One SIMD lane of the execute ALU; purely combinational, no cross-lane carries.
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [3:0]        select,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] result
);

    always_comb begin
        result = '0;
        case (select)
            OP_PASS: result = a;
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SHL:  result = {a[LANE_W-2:0], 1'b0};
            OP_XTIME: begin
                // Each byte of the lane is treated as an independent GF(2^8) element.
                for (int j = 0; j < LANE_W / 8; j++) begin
                    result[j*8 +: 8] = {a[j*8 +: 7], 1'b0} ^ (a[j*8+7] ? AES_POLY : 8'h00);
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/simd_exec_pipe.sv
// SIMD execute pipeline: lane-wise ALU feeding a STAGES-deep elastic slot chain
// with valid/ready handshake, backpressure and synchronous flush.
module simd_exec_pipe
    import simd_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int STAGES = 3,
    parameter int REG_AW = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              select,
    input  logic [LANES*LANE_W-1:0] op1,
    input  logic [LANES*LANE_W-1:0] op2,
    input  logic [REG_AW-1:0]       dir_reg,
    input  logic                    reg_w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] output_a,
    output logic [REG_AW-1:0]       out_dir_reg,
    output logic                    out_reg_w,
    output logic                    out_illegal,
    output logic                    busy
);

    localparam int DATA_W = LANES * LANE_W;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] dir_reg;
        logic              reg_w;
        logic              illegal;
    } slot_t;

    slot_t             slot_q [STAGES];
    slot_t             in_slot;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] valid_vec;
    logic [DATA_W-1:0] alu_res;
    logic              legal;
    logic              accept;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .select (select),
            .a      (op1[k*LANE_W +: LANE_W]),
            .b      (op2[k*LANE_W +: LANE_W]),
            .result (alu_res[k*LANE_W +: LANE_W])
        );
    end

    assign legal    = is_legal_op(select);
    assign in_ready = adv[0] && !reset && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_slot         = '0;
        in_slot.valid   = accept;
        in_slot.data    = alu_res;
        in_slot.dir_reg = dir_reg;
        in_slot.reg_w   = reg_w && legal;
        in_slot.illegal = !legal;
    end

    // Advance ripples backwards from out_ready: a slot moves if it is empty or its successor moves.
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        assign valid_vec[i] = slot_q[i].valid;

        if (i == STAGES - 1) begin : g_adv_last
            assign adv[i] = !slot_q[i].valid || out_ready;
        end else begin : g_adv_mid
            assign adv[i] = !slot_q[i].valid || adv[i+1];
        end

        if (i == 0) begin : g_head
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    slot_q[i].valid <= 1'b0;
                end else if (adv[i]) begin
                    slot_q[i] <= in_slot;
                end
            end
        end else begin : g_body
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    slot_q[i].valid <= 1'b0;
                end else if (adv[i]) begin
                    slot_q[i] <= slot_q[i-1];
                end
            end
        end
    end

    // An entry sitting at the output while flush or reset is high is discarded, never transferred.
    assign out_valid   = slot_q[STAGES-1].valid && !flush && !reset;
    assign output_a    = out_valid ? slot_q[STAGES-1].data    : '0;
    assign out_dir_reg = out_valid ? slot_q[STAGES-1].dir_reg : '0;
    assign out_reg_w   = out_valid ? slot_q[STAGES-1].reg_w   : 1'b0;
    assign out_illegal = out_valid ? slot_q[STAGES-1].illegal : 1'b0;
    assign busy        = |valid_vec;

endmodule

// File: tb/tb_simd_exec_pipe.sv
// Self-checking bench for simd_exec_pipe: directed literal cases plus a
// randomized run scored against an in-order queue model.
module tb_simd_exec_pipe;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int STAGES = 3;
    localparam int REG_AW = 4;
    localparam int DW     = LANES * LANE_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        select = '0;
    logic [DW-1:0]     op1 = '0;
    logic [DW-1:0]     op2 = '0;
    logic [REG_AW-1:0] dir_reg = '0;
    logic              reg_w = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     output_a;
    logic [REG_AW-1:0] out_dir_reg;
    logic              out_reg_w;
    logic              out_illegal;
    logic              busy;

    simd_exec_pipe #(
        .LANES(LANES), .LANE_W(LANE_W), .STAGES(STAGES), .REG_AW(REG_AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .select      (select),
        .op1         (op1),
        .op2         (op2),
        .dir_reg     (dir_reg),
        .reg_w       (reg_w),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_a    (output_a),
        .out_dir_reg (out_dir_reg),
        .out_reg_w   (out_reg_w),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0]     data;
        logic [REG_AW-1:0] dir;
        logic              rw;
        logic              ill;
    } exp_t;

    exp_t              q[$];
    logic              chk_en = 1'b0;
    logic              stall_prev = 1'b0;
    logic [DW-1:0]     prev_a;
    logic [REG_AW-1:0] prev_dir;
    logic              prev_rw;
    logic              prev_ill;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [3:0] sel, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        int x, y, z;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            x = int'(a[k*8 +: 8]);
            y = int'(b[k*8 +: 8]);
            case (sel)
                4'd0: z = x;
                4'd1: z = x ^ y;
                4'd2: z = x & y;
                4'd3: z = x | y;
                4'd4: z = (x + y) % 256;
                4'd5: z = (x - y + 256) % 256;
                4'd6: z = (x * 2) % 256;
                4'd7: z = ((x * 2) % 256) ^ ((x >= 128) ? 27 : 0);
                default: z = 0;
            endcase
            r[k*8 +: 8] = z[7:0];
        end
        return r;
    endfunction

    // Scoreboard: the pipeline must behave as an in-order FIFO of depth STAGES.
    always @(negedge clock) begin
        logic exp_ir;
        exp_t e;
        if (reset) begin
            q.delete();
            stall_prev = 1'b0;
        end else if (chk_en) begin
            exp_ir = !flush && !(q.size() == STAGES && !out_ready);
            chk("in_ready", in_ready, exp_ir);
            chk("busy", busy, q.size() != 0);
            if (stall_prev && !flush) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", output_a, prev_a);
                chk("stall_dir", out_dir_reg, prev_dir);
                chk("stall_rw", out_reg_w, prev_rw);
                chk("stall_ill", out_illegal, prev_ill);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: out_valid=1 with no entry outstanding at t=%0t", $time);
                end else begin
                    chk("out_data", output_a, q[0].data);
                    chk("out_dir", out_dir_reg, q[0].dir);
                    chk("out_rw", out_reg_w, q[0].rw);
                    chk("out_ill", out_illegal, q[0].ill);
                end
            end else begin
                chk("idle_data", output_a, 0);
                chk("idle_fields", {out_dir_reg, out_reg_w, out_illegal}, 0);
            end
            stall_prev = out_valid && !out_ready && !flush;
            prev_a     = output_a;
            prev_dir   = out_dir_reg;
            prev_rw    = out_reg_w;
            prev_ill   = out_illegal;
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && exp_ir) begin
                    e.data = ref_alu(select, op1, op2);
                    e.dir  = dir_reg;
                    e.rw   = reg_w && (select < 4'd8);
                    e.ill  = (select >= 4'd8);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic run_single(input logic [3:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [REG_AW-1:0] d, input logic rw, input logic [DW-1:0] ea,
                              input logic erw, input logic eill, input string name);
        int lat;
        lat = 0;
        select = s; op1 = a; op2 = b; dir_reg = d; reg_w = rw;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        chk({name, "_accept"}, in_ready, 1);
        cyc();
        in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (out_valid) begin
                lat = n;
                break;
            end
            cyc();
        end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_data"}, output_a, ea);
        chk({name, "_dir"}, out_dir_reg, d);
        chk({name, "_rw"}, out_reg_w, erw);
        chk({name, "_ill"}, out_illegal, eill);
        cyc();
    endtask

    initial begin
        int sent, got;
        logic [DW-1:0] hold;

        reset = 1'b1;
        cyc();
        cyc();
        @(negedge clock);
        chk("reset_in_ready", in_ready, 0);
        cyc();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_output_a", output_a, 0);
        chk("rst_fields", {out_dir_reg, out_reg_w, out_illegal}, 0);
        cyc();

        run_single(4'd1, 32'h00FF00FF, 32'h0F0F0F0F, 4'd5, 1'b1, 32'h0FF00FF0, 1'b1, 1'b0, "xor");
        run_single(4'd4, 32'hFF010280, 32'h01FF0280, 4'd2, 1'b1, 32'h00000400, 1'b1, 1'b0, "add");
        run_single(4'd7, 32'h578001FF, 32'h0, 4'd3, 1'b1, 32'hAE1B02E5, 1'b1, 1'b0, "xtime");
        run_single(4'd6, 32'h81C04001, 32'h0, 4'd1, 1'b0, 32'h02808002, 1'b0, 1'b0, "shl");
        run_single(4'd9, 32'h12345678, 32'h9ABCDEF0, 4'd7, 1'b1, 32'h0, 1'b0, 1'b1, "illegal");
        run_single(4'd0, 32'hCAFEF00D, 32'h0, 4'd8, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, "pass_after_ill");

        // Five back-to-back entries, consumer stalls for 4 cycles when the first result shows.
        sent = 0;
        got = 0;
        hold = '0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent < 5);
            select = 4'd3;
            op1 = $urandom;
            op2 = $urandom;
            dir_reg = sent[REG_AW-1:0];
            reg_w = 1'b1;
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clock);
            if (c == 2) chk("bp_ready_before", in_ready, 1);
            if (c == 3) begin
                chk("bp_first_out", out_valid, 1);
                chk("bp_ready_drop", in_ready, 0);
                chk("bp_sent_at_drop", sent, 3);
                hold = output_a;
            end
            if (c == 6) chk("bp_hold", output_a, hold);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got++;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent_total", sent, 5);
        chk("bp_got_total", got, 5);

        // Flush with two entries in flight.
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            select = 4'($urandom_range(0, 7));
            op1 = $urandom;
            op2 = $urandom;
            cyc();
        end
        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", in_ready, 0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("flush_busy", busy, 0);
        cyc();
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            chk("flush_no_out", out_valid, 0);
            cyc();
        end

        // Reset while three entries are held by backpressure.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            select = 4'd2;
            op1 = $urandom;
            op2 = $urandom;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        @(negedge clock);
        chk("hold_busy", busy, 1);
        chk("hold_out_valid", out_valid, 1);
        cyc();
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_in_ready", in_ready, 0);
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_output_a", output_a, 0);
        chk("midrst_fields", {out_dir_reg, out_reg_w, out_illegal}, 0);
        cyc();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            chk("midrst_no_out", out_valid, 0);
            cyc();
        end
        run_single(4'd5, 32'h10203040, 32'h01020304, 4'd9, 1'b1, 32'h0F1E2D3C, 1'b1, 1'b0, "sub_after_rst");

        // Randomized traffic scored by the queue model.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 6;
            flush     = ($urandom % 40) == 0;
            select    = 4'($urandom_range(0, 15));
            op1       = $urandom;
            op2       = $urandom;
            dir_reg   = 4'($urandom);
            reg_w     = 1'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (6) cyc();
        @(negedge clock);
        chk("drain_busy", busy, 0);
        chk("drain_model_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
